sram_arbiter: RTL and testbench
===============================

Name: sram_arbiter

Overview:
- Sits directly upstream of the SRAM controller and drives its BASE_RAM_*_I / EXT_RAM_*_I request inputs.
- Accepts two CPU-side request streams: instruction fetch (IF, read-only) and data memory (MEM, read/write, byte-enabled).
- Decodes the address to BASE or EXT SRAM, arbitrates when both streams target the same RAM, and routes BASE_RAM_RDATA / EXT_RAM_RDATA back to the port that issued the request.
- Responses return one cycle after issue.

Parameters:
- ADDR_W, 32, CPU virtual/physical address width.
- SRAM_AW, 20, SRAM word-address width (matches `SRAM_ADDR_BUS width).
- BASE_PREFIX, 10'h200, addr[31:22] value selecting BASE RAM (0x8000_0000–0x803F_FFFF).
- EXT_PREFIX, 10'h201, addr[31:22] value selecting EXT RAM (0x8040_0000–0x807F_FFFF).

Ports:
- CLK  in  1  clock
- RST  in  1  synchronous reset, active-high (RST_EN = 1)
- IF_REQ  in  1  fetch request; held until IF_VALID
- IF_ADDR  in  ADDR_W  fetch byte address (word-aligned)
- IF_STALL  out  1  combinational; request not issued this cycle
- IF_VALID  out  1  fetch data valid pulse
- IF_RDATA  out  32  fetch data
- MEM_REQ  in  1  data request
- MEM_WE  in  1  1 = write
- MEM_BE  in  4  active-high byte enables (writes only)
- MEM_ADDR  in  ADDR_W  data byte address
- MEM_WDATA  in  32  write data
- MEM_VALID  out  1  read-data-valid / write-done pulse
- MEM_RDATA  out  32  read data (0 for writes)
- {BASE,EXT}_RAM_CE_N_O  out  1  to controller CE_N_I
- {BASE,EXT}_RAM_WE_N_O  out  1  to controller WE_N_I
- {BASE,EXT}_RAM_BE_N_O  out  4  to controller BE_N_I
- {BASE,EXT}_RAM_PADDR_O  out  SRAM_AW  addr[SRAM_AW+1:2]
- {BASE,EXT}_RAM_WDATA_O  out  32  to controller WDATA_I
- {BASE,EXT}_RAM_RDATA  in  32  from controller RDATA
- CONFLICT_CNT  out  32  saturating count of IF stall cycles

Behaviour:
- Decode (combinational): tgt = BASE if addr[31:22]==BASE_PREFIX, EXT if ==EXT_PREFIX, else NONE.
- Issue cycle N, per RAM:
  - MEM has priority.
  - If MEM_REQ targets RAM r, drive r: CE_N=0, WE_N=~MEM_WE, BE_N = MEM_WE ? ~MEM_BE : 4'b0000, PADDR, WDATA.
  - Else if IF_REQ targets r, drive r with a read: CE_N=0, WE_N=1, BE_N=0.
  - Else r idle: CE_N=1, WE_N=1, BE_N=4'hF, PADDR=0, WDATA=0.
- IF_STALL = IF_REQ & MEM_REQ & tgt(IF)==tgt(MEM) & tgt!=NONE. IF re-presents the request next cycle.
- MEM never stalls.
- Response registers, updated every cycle: if_pend, if_src, mem_pend, mem_src, mem_wr, where src ∈ {BASE, EXT, NONE}.
  - if_pend <= IF_REQ & ~IF_STALL.
  - mem_pend <= MEM_REQ.
- Response cycle N+1:
  - IF_VALID = if_pend.
  - IF_RDATA = BASE_RAM_RDATA / EXT_RAM_RDATA by if_src; 0 if NONE.
  - MEM_VALID = mem_pend.
  - MEM_RDATA: data by mem_src when ~mem_wr, else 0.
- Request and response overlap, so one access per port per cycle is sustained (pipelined).
- NONE target:
  - No SRAM activity.
  - Response still pulses next cycle with data 0.
  - Never counts as a conflict.
- CONFLICT_CNT: +1 per cycle IF_STALL=1; saturates at 32'hFFFF_FFFF.
- Reset, synchronous:
  - All pend flags 0; src = NONE; CONFLICT_CNT = 0.
  - IF_VALID = MEM_VALID = 0; RDATA outputs = 0.
  - While RST=1, both RAMs are forced idle (CE_N=WE_N=1, BE_N=F) and IF_STALL=0.
- Reset asserted mid-operation: pending responses are dropped and no VALID pulses; the first cycle after reset deassertion is a legal issue cycle.

Optional Feature:
- Macro SRAM_ARB_ADDR_CHECK_EN.
- Defined:
  - Adds output ADDR_ERR (1 bit), registered, pulsing in N+1 for any request with tgt==NONE or misaligned (addr[1:0]!=0).
  - Misaligned requests are not issued to SRAM; VALID still pulses with data 0.
- Undefined:
  - No ADDR_ERR port.
  - Misaligned addresses are issued with addr[1:0] ignored.
  - NONE behaves as described in Behaviour.

Decomposition:
- Shared package: ram_sel_e enum {SEL_NONE, SEL_BASE, SEL_EXT}; BASE_PREFIX/EXT_PREFIX constants; sram_req_t struct (ce_n, we_n, be_n, paddr, wdata) with an SRAM_REQ_IDLE constant.
- One sub-module, sram_addr_decode: combinational addr → ram_sel_e plus word address, instantiated once per port.

Test Plan:
- IF read 0x8000_0010 alone → BASE CE_N=0, WE_N=1, PADDR=4 in N; N+1 BASE_RAM_RDATA=0xDEADBEEF appears on IF_RDATA with IF_VALID=1.
- MEM write 0x8040_0008, BE=4'b0011, data 0x1234_5678 → EXT WE_N=0, BE_N=4'b1100, PADDR=2; MEM_VALID=1 next cycle, MEM_RDATA=0.
- IF 0x8000_0000 and MEM read 0x8000_0100 same cycle → IF_STALL=1, BASE PADDR=0x40; IF issues next cycle; CONFLICT_CNT=1.
- IF to BASE and MEM to EXT same cycle → both issued, no stall; next cycle both VALID with correct per-RAM data.
- MEM read 0x1000_0000 → no CE on either RAM, MEM_VALID=1 with data 0; ADDR_ERR=1 only with SRAM_ARB_ADDR_CHECK_EN.
- RST asserted the cycle after issue → no VALID pulse; CONFLICT_CNT=0; CE_N=1 on both RAMs.

Source files
------------

// File: rtl/sram_arbiter_pkg.sv
// Shared types and constants for the BASE/EXT SRAM request arbiter.
// Optional address checking is enabled with SRAM_ARB_ADDR_CHECK_EN.
package sram_arbiter_pkg;

  localparam int SRAM_PADDR_W = 20;

  localparam logic [9:0] RAM_BASE_PREFIX = 10'h200;
  localparam logic [9:0] RAM_EXT_PREFIX  = 10'h201;

  typedef enum logic [1:0] {
    SEL_NONE,
    SEL_BASE,
    SEL_EXT
  } ram_sel_e;

  typedef struct packed {
    logic                    ce_n;
    logic                    we_n;
    logic [3:0]              be_n;
    logic [SRAM_PADDR_W-1:0] paddr;
    logic [31:0]             wdata;
  } sram_req_t;

  localparam sram_req_t SRAM_REQ_IDLE = '{
    ce_n:  1'b1,
    we_n:  1'b1,
    be_n:  4'hF,
    paddr: '0,
    wdata: '0
  };

endpackage

// File: rtl/sram_addr_decode.sv
// Byte address to RAM select plus SRAM word address.
// Also flags a misaligned byte address for the optional checker.
module sram_addr_decode
  import sram_arbiter_pkg::*;
#(
  parameter int         ADDR_W      = 32,
  parameter int         SRAM_AW     = 20,
  parameter logic [9:0] BASE_PREFIX = RAM_BASE_PREFIX,
  parameter logic [9:0] EXT_PREFIX  = RAM_EXT_PREFIX
) (
  input  logic [ADDR_W-1:0]  addr,
  output ram_sel_e           sel,
  output logic [SRAM_AW-1:0] paddr,
  output logic               misal
);

  logic [9:0] pfx;

  assign pfx   = addr[ADDR_W-1 -: 10];
  assign paddr = addr[SRAM_AW+1:2];
  assign misal = |addr[1:0];

  // Prefix match picks the RAM; anything else is unmapped
  always_comb begin
    sel = SEL_NONE;
    unique case (1'b1)
      (pfx == BASE_PREFIX): sel = SEL_BASE;
      (pfx == EXT_PREFIX):  sel = SEL_EXT;
      default:              sel = SEL_NONE;
    endcase
  end

endmodule

// File: rtl/sram_arbiter.sv
// Two-port (IF/MEM) arbiter in front of the BASE/EXT SRAM controllers.
// Define SRAM_ARB_ADDR_CHECK_EN to add the ADDR_ERR output.
module sram_arbiter
  import sram_arbiter_pkg::*;
#(
  parameter int         ADDR_W      = 32,
  parameter int         SRAM_AW     = SRAM_PADDR_W,
  parameter logic [9:0] BASE_PREFIX = RAM_BASE_PREFIX,
  parameter logic [9:0] EXT_PREFIX  = RAM_EXT_PREFIX
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               IF_REQ,
  input  logic [ADDR_W-1:0]  IF_ADDR,
  output logic               IF_STALL,
  output logic               IF_VALID,
  output logic [31:0]        IF_RDATA,
  input  logic               MEM_REQ,
  input  logic               MEM_WE,
  input  logic [3:0]         MEM_BE,
  input  logic [ADDR_W-1:0]  MEM_ADDR,
  input  logic [31:0]        MEM_WDATA,
  output logic               MEM_VALID,
  output logic [31:0]        MEM_RDATA,
  output logic               BASE_RAM_CE_N_O,
  output logic               BASE_RAM_WE_N_O,
  output logic [3:0]         BASE_RAM_BE_N_O,
  output logic [SRAM_AW-1:0] BASE_RAM_PADDR_O,
  output logic [31:0]        BASE_RAM_WDATA_O,
  input  logic [31:0]        BASE_RAM_RDATA,
  output logic               EXT_RAM_CE_N_O,
  output logic               EXT_RAM_WE_N_O,
  output logic [3:0]         EXT_RAM_BE_N_O,
  output logic [SRAM_AW-1:0] EXT_RAM_PADDR_O,
  output logic [31:0]        EXT_RAM_WDATA_O,
  input  logic [31:0]        EXT_RAM_RDATA,
`ifdef SRAM_ARB_ADDR_CHECK_EN
  output logic               ADDR_ERR,
`endif
  output logic [31:0]        CONFLICT_CNT
);

  ram_sel_e           if_tgt, mem_tgt;
  ram_sel_e           if_sel, mem_sel;
  logic [SRAM_AW-1:0] if_pa, mem_pa;
  logic               if_mis, mem_mis;
  sram_req_t          base_req, ext_req;
  logic               if_pend, mem_pend, mem_wr;
  ram_sel_e           if_src, mem_src;
  logic               if_go;

  sram_addr_decode #(
    .ADDR_W     (ADDR_W),
    .SRAM_AW    (SRAM_AW),
    .BASE_PREFIX(BASE_PREFIX),
    .EXT_PREFIX (EXT_PREFIX)
  ) u_if_dec (
    .addr (IF_ADDR),
    .sel  (if_tgt),
    .paddr(if_pa),
    .misal(if_mis)
  );

  sram_addr_decode #(
    .ADDR_W     (ADDR_W),
    .SRAM_AW    (SRAM_AW),
    .BASE_PREFIX(BASE_PREFIX),
    .EXT_PREFIX (EXT_PREFIX)
  ) u_mem_dec (
    .addr (MEM_ADDR),
    .sel  (mem_tgt),
    .paddr(mem_pa),
    .misal(mem_mis)
  );

`ifdef SRAM_ARB_ADDR_CHECK_EN
  logic addr_err_q;

  assign if_sel   = if_mis  ? SEL_NONE : if_tgt;
  assign mem_sel  = mem_mis ? SEL_NONE : mem_tgt;
  assign ADDR_ERR = addr_err_q & ~RST;

  // Error flag follows the issued request into the response cycle
  always_ff @(posedge CLK) begin
    if (RST) begin
      addr_err_q <= 1'b0;
    end else begin
      addr_err_q <= (if_go & (if_tgt == SEL_NONE | if_mis))
                  | (MEM_REQ & (mem_tgt == SEL_NONE | mem_mis));
    end
  end
`else
  logic unused_mis;

  assign if_sel     = if_tgt;
  assign mem_sel    = mem_tgt;
  assign unused_mis = if_mis ^ mem_mis;
`endif

  function automatic sram_req_t pick(
    input logic               rst,
    input logic               mem_hit,
    input logic               if_hit,
    input logic               we,
    input logic [3:0]         be,
    input logic [SRAM_AW-1:0] mpa,
    input logic [SRAM_AW-1:0] ipa,
    input logic [31:0]        wd
  );
    sram_req_t r;
    r = SRAM_REQ_IDLE;
    if (!rst && mem_hit) begin
      r.ce_n  = 1'b0;
      r.we_n  = ~we;
      r.be_n  = we ? ~be : 4'h0;
      r.paddr = mpa;
      r.wdata = wd;
    end else if (!rst && if_hit) begin
      r.ce_n  = 1'b0;
      r.we_n  = 1'b1;
      r.be_n  = 4'h0;
      r.paddr = ipa;
      r.wdata = '0;
    end
    return r;
  endfunction

  function automatic logic [31:0] rd_mux(
    input ram_sel_e    s,
    input logic [31:0] b,
    input logic [31:0] e
  );
    case (s)
      SEL_BASE: return b;
      SEL_EXT:  return e;
      default:  return 32'h0;
    endcase
  endfunction

  assign IF_STALL = ~RST & IF_REQ & MEM_REQ
                  & (if_sel == mem_sel)
                  & (if_sel != SEL_NONE);
  assign if_go    = IF_REQ & ~IF_STALL;

  assign base_req = pick(RST,
    MEM_REQ && mem_sel == SEL_BASE,
    IF_REQ  && if_sel  == SEL_BASE,
    MEM_WE, MEM_BE, mem_pa, if_pa, MEM_WDATA);

  assign ext_req = pick(RST,
    MEM_REQ && mem_sel == SEL_EXT,
    IF_REQ  && if_sel  == SEL_EXT,
    MEM_WE, MEM_BE, mem_pa, if_pa, MEM_WDATA);

  assign BASE_RAM_CE_N_O  = base_req.ce_n;
  assign BASE_RAM_WE_N_O  = base_req.we_n;
  assign BASE_RAM_BE_N_O  = base_req.be_n;
  assign BASE_RAM_PADDR_O = base_req.paddr;
  assign BASE_RAM_WDATA_O = base_req.wdata;
  assign EXT_RAM_CE_N_O   = ext_req.ce_n;
  assign EXT_RAM_WE_N_O   = ext_req.we_n;
  assign EXT_RAM_BE_N_O   = ext_req.be_n;
  assign EXT_RAM_PADDR_O  = ext_req.paddr;
  assign EXT_RAM_WDATA_O  = ext_req.wdata;

  // Record where each issued request went, for next-cycle routing
  always_ff @(posedge CLK) begin
    if (RST) begin
      if_pend      <= 1'b0;
      if_src       <= SEL_NONE;
      mem_pend     <= 1'b0;
      mem_src      <= SEL_NONE;
      mem_wr       <= 1'b0;
      CONFLICT_CNT <= 32'h0;
    end else begin
      if_pend  <= if_go;
      if_src   <= if_go ? if_sel : SEL_NONE;
      mem_pend <= MEM_REQ;
      mem_src  <= MEM_REQ ? mem_sel : SEL_NONE;
      mem_wr   <= MEM_REQ & MEM_WE;
      if (IF_STALL && CONFLICT_CNT != 32'hFFFF_FFFF)
        CONFLICT_CNT <= CONFLICT_CNT + 32'h1;
    end
  end

  assign IF_VALID  = if_pend & ~RST;
  assign MEM_VALID = mem_pend & ~RST;
  assign IF_RDATA  = RST ? 32'h0
                   : rd_mux(if_src, BASE_RAM_RDATA, EXT_RAM_RDATA);
  assign MEM_RDATA = (RST || mem_wr) ? 32'h0
                   : rd_mux(mem_src, BASE_RAM_RDATA, EXT_RAM_RDATA);

endmodule

// File: tb/tb_sram_arbiter.sv
// Scoreboard bench for sram_arbiter: directed plan cases, then random
// IF/MEM traffic with occasional resets.
module tb_sram_arbiter;

  logic        CLK = 1'b0;
  logic        RST;
  logic        IF_REQ;
  logic [31:0] IF_ADDR;
  logic        IF_STALL, IF_VALID;
  logic [31:0] IF_RDATA;
  logic        MEM_REQ, MEM_WE;
  logic [3:0]  MEM_BE;
  logic [31:0] MEM_ADDR, MEM_WDATA;
  logic        MEM_VALID;
  logic [31:0] MEM_RDATA;
  logic        BASE_RAM_CE_N_O, BASE_RAM_WE_N_O;
  logic [3:0]  BASE_RAM_BE_N_O;
  logic [19:0] BASE_RAM_PADDR_O;
  logic [31:0] BASE_RAM_WDATA_O, BASE_RAM_RDATA;
  logic        EXT_RAM_CE_N_O, EXT_RAM_WE_N_O;
  logic [3:0]  EXT_RAM_BE_N_O;
  logic [19:0] EXT_RAM_PADDR_O;
  logic [31:0] EXT_RAM_WDATA_O, EXT_RAM_RDATA;
  logic [31:0] CONFLICT_CNT;
`ifdef SRAM_ARB_ADDR_CHECK_EN
  logic        ADDR_ERR;
`endif

  sram_arbiter dut (
    .CLK             (CLK),
    .RST             (RST),
    .IF_REQ          (IF_REQ),
    .IF_ADDR         (IF_ADDR),
    .IF_STALL        (IF_STALL),
    .IF_VALID        (IF_VALID),
    .IF_RDATA        (IF_RDATA),
    .MEM_REQ         (MEM_REQ),
    .MEM_WE          (MEM_WE),
    .MEM_BE          (MEM_BE),
    .MEM_ADDR        (MEM_ADDR),
    .MEM_WDATA       (MEM_WDATA),
    .MEM_VALID       (MEM_VALID),
    .MEM_RDATA       (MEM_RDATA),
    .BASE_RAM_CE_N_O (BASE_RAM_CE_N_O),
    .BASE_RAM_WE_N_O (BASE_RAM_WE_N_O),
    .BASE_RAM_BE_N_O (BASE_RAM_BE_N_O),
    .BASE_RAM_PADDR_O(BASE_RAM_PADDR_O),
    .BASE_RAM_WDATA_O(BASE_RAM_WDATA_O),
    .BASE_RAM_RDATA  (BASE_RAM_RDATA),
    .EXT_RAM_CE_N_O  (EXT_RAM_CE_N_O),
    .EXT_RAM_WE_N_O  (EXT_RAM_WE_N_O),
    .EXT_RAM_BE_N_O  (EXT_RAM_BE_N_O),
    .EXT_RAM_PADDR_O (EXT_RAM_PADDR_O),
    .EXT_RAM_WDATA_O (EXT_RAM_WDATA_O),
    .EXT_RAM_RDATA   (EXT_RAM_RDATA),
`ifdef SRAM_ARB_ADDR_CHECK_EN
    .ADDR_ERR        (ADDR_ERR),
`endif
    .CONFLICT_CNT    (CONFLICT_CNT)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    int t;
    bit wr;
  } mem_ent_t;

  int       checks = 0;
  int       errors = 0;
  int       if_q[$];
  mem_ent_t mem_q[$];
  int       cnt = 0;

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  function automatic int tgt(input logic [31:0] a);
    case (a[31:22])
      10'h200: return 1;
      10'h201: return 2;
      default: return 0;
    endcase
  endfunction

  function automatic logic [31:0] rdat(input int t);
    case (t)
      1:       return BASE_RAM_RDATA;
      2:       return EXT_RAM_RDATA;
      default: return 32'h0;
    endcase
  endfunction

  // {ce_n, we_n, be_n, paddr, wdata} expected on RAM r
  function automatic logic [57:0] exp_ram(
    input int r, input bit rst,
    input bit ifr, input logic [31:0] ifa,
    input bit mr, input bit we, input logic [3:0] be,
    input logic [31:0] ma, input logic [31:0] wd);
    if (!rst && mr && tgt(ma) == r)
      return {1'b0, ~we, we ? ~be : 4'h0, ma[21:2], wd};
    if (!rst && ifr && tgt(ifa) == r)
      return {1'b0, 1'b1, 4'h0, ifa[21:2], 32'h0};
    return {1'b1, 1'b1, 4'hF, 20'h0, 32'h0};
  endfunction

  task automatic step(
    input bit rst,
    input bit ifr, input logic [31:0] ifa,
    input bit mr, input bit we, input logic [3:0] be,
    input logic [31:0] ma, input logic [31:0] wd);
    bit       stall;
    int       ti, tm, e;
    mem_ent_t me;
    RST = rst;
    IF_REQ = ifr;
    IF_ADDR = ifa;
    MEM_REQ = mr;
    MEM_WE = we;
    MEM_BE = be;
    MEM_ADDR = ma;
    MEM_WDATA = wd;
    BASE_RAM_RDATA = $urandom;
    EXT_RAM_RDATA = $urandom;
    @(negedge CLK);
    if (rst) begin
      chk("if_valid_rst", IF_VALID, 0);
      chk("mem_valid_rst", MEM_VALID, 0);
      chk("if_rdata_rst", IF_RDATA, 0);
      chk("mem_rdata_rst", MEM_RDATA, 0);
      if_q.delete();
      mem_q.delete();
    end else begin
      if (if_q.size() > 0) begin
        e = if_q.pop_front();
        chk("if_valid", IF_VALID, 1);
        chk("if_rdata", IF_RDATA, rdat(e));
      end else begin
        chk("if_valid_idle", IF_VALID, 0);
      end
      if (mem_q.size() > 0) begin
        me = mem_q.pop_front();
        chk("mem_valid", MEM_VALID, 1);
        chk("mem_rdata", MEM_RDATA,
            me.wr ? 32'h0 : rdat(me.t));
      end else begin
        chk("mem_valid_idle", MEM_VALID, 0);
      end
      chk("conflict_cnt", CONFLICT_CNT, cnt);
    end
    ti = tgt(ifa);
    tm = tgt(ma);
    stall = !rst && ifr && mr && ti == tm && ti != 0;
    chk("if_stall", IF_STALL, stall);
    chk("base_req",
        {BASE_RAM_CE_N_O, BASE_RAM_WE_N_O, BASE_RAM_BE_N_O,
         BASE_RAM_PADDR_O, BASE_RAM_WDATA_O},
        exp_ram(1, rst, ifr, ifa, mr, we, be, ma, wd));
    chk("ext_req",
        {EXT_RAM_CE_N_O, EXT_RAM_WE_N_O, EXT_RAM_BE_N_O,
         EXT_RAM_PADDR_O, EXT_RAM_WDATA_O},
        exp_ram(2, rst, ifr, ifa, mr, we, be, ma, wd));
    @(posedge CLK);
    if (rst) begin
      cnt = 0;
    end else begin
      if (stall) cnt++;
      if (ifr && !stall) if_q.push_back(ti);
      if (mr) begin
        me.t = tm;
        me.wr = we;
        mem_q.push_back(me);
      end
    end
    #1;
  endtask

  task automatic idle();
    step(0, 0, 32'h0, 0, 0, 4'h0, 32'h0, 32'h0);
  endtask

  function automatic logic [31:0] rnd_addr();
    logic [9:0] p;
    case ($urandom_range(0, 3))
      0:       p = 10'h200;
      1:       p = 10'h201;
      2:       p = 10'h040;
      default: p = 10'($urandom);
    endcase
    return {p, 20'($urandom), 2'b00};
  endfunction

  initial begin
    RST = 1'b1;
    IF_REQ = 0; IF_ADDR = 0;
    MEM_REQ = 0; MEM_WE = 0; MEM_BE = 0;
    MEM_ADDR = 0; MEM_WDATA = 0;
    BASE_RAM_RDATA = 0; EXT_RAM_RDATA = 0;

    step(1, 0, 0, 0, 0, 0, 0, 0);
    step(1, 1, 32'h8000_0000, 1, 0, 0, 32'h8000_0100, 0);
    idle();
    chk("cnt_after_reset", CONFLICT_CNT, 0);

    // IF read alone, BASE word 4
    step(0, 1, 32'h8000_0010, 0, 0, 0, 0, 0);
    idle();
    // MEM write to EXT, partial byte enables
    step(0, 0, 0, 1, 1, 4'b0011, 32'h8040_0008,
         32'h1234_5678);
    idle();
    // Same-RAM conflict, IF retries next cycle
    step(0, 1, 32'h8000_0000, 1, 0, 0, 32'h8000_0100, 0);
    step(0, 1, 32'h8000_0000, 0, 0, 0, 0, 0);
    idle();
    chk("cnt_one", CONFLICT_CNT, 1);
    // IF to BASE, MEM to EXT in parallel
    step(0, 1, 32'h8000_0020, 1, 0, 0, 32'h8040_0030, 0);
    idle();
    // Unmapped MEM read
    step(0, 0, 0, 1, 0, 0, 32'h1000_0000, 0);
    idle();
    // Back-to-back pipelined accesses
    step(0, 1, 32'h8000_0040, 1, 1, 4'hF, 32'h8040_0044,
         32'hA5A5_5A5A);
    step(0, 1, 32'h8040_0048, 1, 0, 0, 32'h8000_004C, 0);
    idle();
    // Reset the cycle after issue drops the response
    step(0, 1, 32'h8000_0010, 1, 0, 0, 32'h8040_0010, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0);
    idle();
    chk("cnt_cleared", CONFLICT_CNT, 0);

    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 49) == 0,
           $urandom_range(0, 3) != 0, rnd_addr(),
           $urandom_range(0, 2) != 0, 1'($urandom),
           4'($urandom), rnd_addr(), $urandom);
    end
    idle();
    idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
